// File: rtl/result_demux_1to8.sv
// 1-to-8 result demultiplexer with a one-entry registered holding buffer per channel.
// Optional per-channel delivered-word counters are enabled with `define DEMUX_STATS_EN.
module result_demux_1to8 #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_sel,
    input  logic [BIT_WIDTH-1:0]   in_data,
    output logic [7:0]             out_valid,
    input  logic [7:0]             out_ready,
    output logic [8*BIT_WIDTH-1:0] out_data,
`ifdef DEMUX_STATS_EN
    input  logic                   stat_clr,
    output logic [8*16-1:0]        stat_count,
`endif
    output logic                   busy
);

    logic [7:0]           r_full;
    logic [BIT_WIDTH-1:0] r_hold [8];

    logic       w_push;
    logic [7:0] w_push_oh;
    logic [7:0] w_pop;

    // A full channel can still accept when its consumer drains it in the same cycle.
    assign in_ready = rst_n & (~r_full[in_sel] | out_ready[in_sel]);
    assign w_push   = in_valid & in_ready;
    assign w_pop    = r_full & out_ready;

    always_comb begin
        w_push_oh = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (w_push && (in_sel == 3'(k))) begin
                w_push_oh[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 8'h00;
            for (int k = 0; k < 8; k++) begin
                r_hold[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (w_push_oh[k]) begin
                    r_full[k] <= 1'b1;
                    r_hold[k] <= in_data;
                end else if (w_pop[k]) begin
                    r_full[k] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_full;
    assign busy      = |r_full;

    always_comb begin
        out_data = '0;
        for (int k = 0; k < 8; k++) begin
            out_data[k*BIT_WIDTH +: BIT_WIDTH] = r_hold[k];
        end
    end

`ifdef DEMUX_STATS_EN
    logic [15:0] r_stat [8];

    // Clear wins over a same-cycle pop; counters wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                r_stat[k] <= 16'h0000;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (stat_clr) begin
                    r_stat[k] <= 16'h0000;
                end else if (w_pop[k]) begin
                    r_stat[k] <= r_stat[k] + 16'h0001;
                end
            end
        end
    end

    always_comb begin
        stat_count = '0;
        for (int k = 0; k < 8; k++) begin
            stat_count[k*16 +: 16] = r_stat[k];
        end
    end
`endif

endmodule

// File: tb/tb_result_demux_1to8.sv
// Directed bench for result_demux_1to8: queue-per-channel model checked every cycle,
// plus literal expectations. Stats checks are compiled when DEMUX_STATS_EN is defined.
module tb_result_demux_1to8;

    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     in_sel;
    logic [W-1:0]   in_data;
    logic [7:0]     out_valid;
    logic [7:0]     out_ready;
    logic [8*W-1:0] out_data;
    logic           busy;
`ifdef DEMUX_STATS_EN
    logic           stat_clr;
    logic [8*16-1:0] stat_count;
`endif

    int total = 0;
    int bad   = 0;
    bit cmp_en = 0;

    result_demux_1to8 #(.BIT_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef DEMUX_STATS_EN
        .stat_clr  (stat_clr),
        .stat_count(stat_count),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each channel is a queue holding at most one word; counters are plain ints.
    logic [W-1:0] mq [8][$];
    int           mcnt [8];

    function automatic bit exp_ready();
        return rst_n && ((mq[in_sel].size() == 0) || out_ready[in_sel]);
    endfunction

    always @(negedge rst_n) begin
        for (int k = 0; k < 8; k++) begin
            mq[k].delete();
            mcnt[k] = 0;
        end
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            automatic bit          push = in_valid && exp_ready();
            automatic logic [2:0]  s    = in_sel;
            automatic logic [W-1:0] d   = in_data;
            for (int k = 0; k < 8; k++) begin
                if (mq[k].size() > 0 && out_ready[k]) begin
                    void'(mq[k].pop_front());
`ifdef DEMUX_STATS_EN
                    mcnt[k] = (mcnt[k] + 1) % 65536;
`endif
                end
`ifdef DEMUX_STATS_EN
                if (stat_clr) mcnt[k] = 0;
`endif
            end
            if (push) mq[s].push_back(d);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            automatic logic [7:0] ev = '0;
            for (int k = 0; k < 8; k++) ev[k] = (mq[k].size() > 0);
            chk("m_out_valid", out_valid, ev);
            chk("m_busy", busy, |ev);
            chk("m_in_ready", in_ready, exp_ready());
            for (int k = 0; k < 8; k++) begin
                if (mq[k].size() > 0) chk($sformatf("m_data%0d", k), out_data[k*W +: W], mq[k][0]);
`ifdef DEMUX_STATS_EN
                chk($sformatf("m_cnt%0d", k), stat_count[k*16 +: 16], 16'(mcnt[k]));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]   sel;
        logic [W-1:0] data;
        logic         vld;
        logic [7:0]   rdy;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 3'd0; in_data = '0; out_ready = 8'h00;
`ifdef DEMUX_STATS_EN
        stat_clr = 1'b0;
`endif
        cmp_en = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        rst_n = 1'b1;

        // Single push to channel 3 with no consumer.
        in_sel = 3'd3; in_data = 32'hDEADBEEF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", out_valid, 8'h08);
        chk("t1_slice3", out_data[3*W +: W], 32'hDEADBEEF);
        chk("t1_busy", busy, 1'b1);
        chk("t1_ready_sel3", in_ready, 1'b0);
        in_sel = 3'd5;
        #1;
        chk("t1_ready_sel5", in_ready, 1'b1);

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_hold", out_data[3*W +: W], 32'hDEADBEEF);
        end
        out_ready = 8'h08;
        tick();
        chk("t2_drained", out_valid, 8'h00);
        chk("t2_busy", busy, 1'b0);
        out_ready = 8'h00;

        // Full-throughput stream on channel 6.
        out_ready = 8'h40;
        for (int i = 1; i <= 4; i++) begin
            in_sel = 3'd6; in_data = W'(i); in_valid = 1'b1;
            #1;
            chk("t3_in_ready", in_ready, 1'b1);
            tick();
            chk("t3_valid6", out_valid, 8'h40);
            chk("t3_data6", out_data[6*W +: W], 64'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("t3_empty", out_valid, 8'h00);
        out_ready = 8'h00;

        // Pops on 0 and 7 alongside a push to 2.
        in_valid = 1'b1; in_sel = 3'd0; in_data = 32'hA;
        tick();
        in_sel = 3'd7; in_data = 32'hB;
        tick();
        chk("t4_filled", out_valid, 8'h81);
        in_sel = 3'd2; in_data = 32'hC; out_ready = 8'h81;
        tick();
        in_valid = 1'b0; out_ready = 8'h00;
        chk("t4_out_valid", out_valid, 8'h04);
        chk("t4_slice2", out_data[2*W +: W], 32'hC);
        out_ready = 8'h04;
        tick();
        out_ready = 8'h00;

        // Asynchronous reset mid-cycle with channel 1 full.
        in_valid = 1'b1; in_sel = 3'd1; in_data = 32'h11;
        tick();
        in_valid = 1'b0;
        chk("t5_filled", out_valid, 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", out_valid, 8'h00);
        chk("t5_async_busy", busy, 1'b0);
        chk("t5_async_ready", in_ready, 1'b0);
        in_valid = 1'b1; in_data = 32'h99;
        tick();
        chk("t5_dropped", out_valid, 8'h00);
        rst_n = 1'b1; in_data = 32'h22;
        tick();
        in_valid = 1'b0;
        chk("t5_first_edge", out_valid, 8'h02);
        chk("t5_first_data", out_data[1*W +: W], 32'h22);
        out_ready = 8'h02;
        tick();
        out_ready = 8'h00;

        // Mixed directed vectors checked by the model.
        tbl[0] = '{3'd0, 32'h100, 1'b1, 8'h00};
        tbl[1] = '{3'd0, 32'h101, 1'b1, 8'h00};
        tbl[2] = '{3'd1, 32'h200, 1'b1, 8'h01};
        tbl[3] = '{3'd1, 32'h201, 1'b1, 8'h00};
        tbl[4] = '{3'd1, 32'h202, 1'b1, 8'h02};
        tbl[5] = '{3'd5, 32'h0,   1'b0, 8'hFF};
        tbl[6] = '{3'd5, 32'h500, 1'b1, 8'h20};
        foreach (tbl[i]) begin
            in_sel = tbl[i].sel; in_data = tbl[i].data;
            in_valid = tbl[i].vld; out_ready = tbl[i].rdy;
            tick();
        end
        in_valid = 1'b0; out_ready = 8'h00;
        chk("t6_out_valid", out_valid, 8'h20);
        chk("t6_slice5", out_data[5*W +: W], 32'h500);
        out_ready = 8'hFF;
        tick();
        out_ready = 8'h00;
        chk("t6_drained", out_valid, 8'h00);

`ifdef DEMUX_STATS_EN
        out_ready = 8'h10; in_sel = 3'd4; in_data = 32'h44; in_valid = 1'b1;
        repeat (5) tick();
        in_valid = 1'b0;
        tick();
        chk("s_five", stat_count[4*16 +: 16], 16'd5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("s_clr_prio", stat_count[4*16 +: 16], 16'd0);
        in_valid = 1'b1;
        repeat (65535) tick();
        in_valid = 1'b0;
        tick();
        chk("s_ffff", stat_count[4*16 +: 16], 16'hFFFF);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("s_wrap", stat_count[4*16 +: 16], 16'h0000);
        out_ready = 8'h00;
`endif

        tick();
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
